// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong screen constants, RGB width and ball FSM encoding
package pong_pkg;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int RGB_W    = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    MOVE  = 2'd2,
    SCORE = 2'd3
  } ball_state_t;
endpackage

// File: rtl/draw_ball_ctl_if.sv
// rtl/draw_ball_ctl_if.sv - VGA timing plus RGB pixel bundle passed between pipeline stages
interface draw_ball_ctl_if;
  import pong_pkg::*;

  logic [10:0]      vcount;
  logic [10:0]      hcount;
  logic             vsync;
  logic             hsync;
  logic             vblnk;
  logic             hblnk;
  logic [RGB_W-1:0] rgb;

  modport master (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport slave  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/ball_draw.sv
// rtl/ball_draw.sv - ball overlay comparator and 1-cycle timing/RGB pipeline register
module ball_draw
  import pong_pkg::*;
#(
  parameter int               BALL_SIZE  = 16,
  parameter logic [RGB_W-1:0] BALL_COLOR = 12'hFFF
) (
  input  logic                   pclk,
  input  logic                   rst,
  draw_ball_ctl_if.slave         vga_in,
  draw_ball_ctl_if.master        vga_out,
  input  logic [11:0]            ball_x,
  input  logic [11:0]            ball_y
);
  localparam logic [12:0] BSU = 13'(BALL_SIZE);

  logic [12:0]      w_h, w_v, w_bx, w_by;
  logic             w_in_ball;
  logic [10:0]      r_vcount, r_hcount;
  logic             r_vsync, r_hsync, r_vblnk, r_hblnk;
  logic [RGB_W-1:0] r_rgb;

  assign w_h  = {2'b00, vga_in.hcount};
  assign w_v  = {2'b00, vga_in.vcount};
  assign w_bx = {1'b0, ball_x};
  assign w_by = {1'b0, ball_y};

  assign w_in_ball = (w_h >= w_bx) && (w_h < w_bx + BSU) &&
                     (w_v >= w_by) && (w_v < w_by + BSU) &&
                     !vga_in.hblnk && !vga_in.vblnk;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vcount <= '0;
      r_hcount <= '0;
      r_vsync  <= 1'b0;
      r_hsync  <= 1'b0;
      r_vblnk  <= 1'b0;
      r_hblnk  <= 1'b0;
      r_rgb    <= '0;
    end else begin
      r_vcount <= vga_in.vcount;
      r_hcount <= vga_in.hcount;
      r_vsync  <= vga_in.vsync;
      r_hsync  <= vga_in.hsync;
      r_vblnk  <= vga_in.vblnk;
      r_hblnk  <= vga_in.hblnk;
      r_rgb    <= w_in_ball ? BALL_COLOR : vga_in.rgb;
    end
  end

  assign vga_out.vcount = r_vcount;
  assign vga_out.hcount = r_hcount;
  assign vga_out.vsync  = r_vsync;
  assign vga_out.hsync  = r_hsync;
  assign vga_out.vblnk  = r_vblnk;
  assign vga_out.hblnk  = r_hblnk;
  assign vga_out.rgb    = r_rgb;
endmodule

// File: rtl/draw_ball_ctl.sv
// rtl/draw_ball_ctl.sv - Pong ball engine: frame tick, serve/move/score FSM, bounces, score pulses
// Optional BALL_SPEEDUP_EN: every paddle hit adds 1 to speed, saturating at MAX_SPEED.
module draw_ball_ctl
  import pong_pkg::*;
#(
  parameter int               H_ACTIVE     = pong_pkg::H_ACTIVE,
  parameter int               V_ACTIVE     = pong_pkg::V_ACTIVE,
  parameter int               BALL_SIZE    = 16,
  parameter logic [RGB_W-1:0] BALL_COLOR   = 12'hFFF,
  parameter int               SPEED        = 2,
  parameter int               MAX_SPEED    = 8,
  parameter int               PADDLE_W     = 10,
  parameter int               PADDLE_H     = 80,
  parameter int               PADDLE_X_L   = 20,
  parameter int               PADDLE_X_R   = 770,
  parameter int               SERVE_FRAMES = 60
) (
  input  logic                   pclk,
  input  logic                   rst,
  draw_ball_ctl_if.slave         vga_in,
  draw_ball_ctl_if.master        vga_out,
  input  logic [11:0]            paddle_l_y,
  input  logic [11:0]            paddle_r_y,
  input  logic                   game_en,
  output logic [11:0]            ball_x,
  output logic [11:0]            ball_y,
  output logic                   score_l,
  output logic                   score_r
);
  localparam int SPD_W = $clog2(((MAX_SPEED > SPEED) ? MAX_SPEED : SPEED) + 1);
  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [11:0]        CX       = 12'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0]        CY       = 12'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0]        Y_MAX    = 12'(V_ACTIVE - BALL_SIZE);
  localparam logic [11:0]        X_R_STOP = 12'(PADDLE_X_R - BALL_SIZE);
  localparam logic [11:0]        X_L_STOP = 12'(PADDLE_X_L + PADDLE_W);
  localparam logic signed [12:0] BS       = 13'(BALL_SIZE);
  localparam logic signed [12:0] HA       = 13'(H_ACTIVE);
  localparam logic signed [12:0] VA       = 13'(V_ACTIVE);
  localparam logic signed [12:0] XR       = 13'(PADDLE_X_R);
  localparam logic signed [12:0] XL       = 13'(PADDLE_X_L + PADDLE_W);
  localparam logic [12:0]        BSU      = 13'(BALL_SIZE);
  localparam logic [12:0]        PH       = 13'(PADDLE_H);
  localparam logic [SPD_W-1:0]   SPD0     = SPD_W'(SPEED);

  ball_state_t        r_state, w_state;
  logic [11:0]        r_x, w_x, r_y, w_y;
  logic               r_dx, w_dx, r_dy, w_dy;
  logic [SPD_W-1:0]   r_speed, w_speed, w_speed_hit;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic               r_vblnk_d, r_score_l, r_score_r, w_score_l, w_score_r;
  logic               w_tick;
  logic signed [12:0] w_xs, w_ys, w_spd, w_nx, w_ny;
  logic               w_ovl_l, w_ovl_r, w_hit_l, w_hit_r, w_miss_l, w_miss_r;

  assign w_tick = vga_in.vblnk & ~r_vblnk_d;

  assign w_xs  = $signed({1'b0, r_x});
  assign w_ys  = $signed({1'b0, r_y});
  assign w_spd = $signed(13'(r_speed));
  assign w_nx  = r_dx ? w_xs + w_spd : w_xs - w_spd;
  assign w_ny  = r_dy ? w_ys + w_spd : w_ys - w_spd;

  assign w_ovl_r = ({1'b0, r_y} + BSU > {1'b0, paddle_r_y}) && ({1'b0, r_y} < {1'b0, paddle_r_y} + PH);
  assign w_ovl_l = ({1'b0, r_y} + BSU > {1'b0, paddle_l_y}) && ({1'b0, r_y} < {1'b0, paddle_l_y} + PH);

  // Contact only counts if the ball was still in front of the paddle face before this step.
  assign w_hit_r  =  r_dx && (w_nx + BS >= XR) && (w_xs + BS <= XR) && w_ovl_r;
  assign w_hit_l  = !r_dx && (w_nx <= XL) && (w_xs >= XL) && w_ovl_l;
  assign w_miss_l =  r_dx && (w_nx + BS >= HA);
  assign w_miss_r = !r_dx && (w_nx <= 13'sd0);

`ifdef BALL_SPEEDUP_EN
  assign w_speed_hit = (r_speed < SPD_W'(MAX_SPEED)) ? r_speed + 1'b1 : r_speed;
`else
  assign w_speed_hit = r_speed;
`endif

  always_comb begin
    w_state   = r_state;
    w_x       = r_x;
    w_y       = r_y;
    w_dx      = r_dx;
    w_dy      = r_dy;
    w_speed   = r_speed;
    w_cnt     = r_cnt;
    w_score_l = 1'b0;
    w_score_r = 1'b0;
    if (!game_en) begin
      w_state = IDLE;
      w_x     = CX;
      w_y     = CY;
      w_speed = SPD0;
      w_cnt   = '0;
    end else if (w_tick) begin
      case (r_state)
        // The tick that enters SERVE is the first of the held frames.
        IDLE: begin
          w_state = SERVE;
          w_cnt   = CNT_W'(1);
        end
        SERVE: begin
          if (int'(r_cnt) + 1 >= SERVE_FRAMES) w_state = MOVE;
          else                                  w_cnt   = r_cnt + 1'b1;
        end
        MOVE: begin
          if (w_ny <= 13'sd0) begin
            w_y  = '0;
            w_dy = ~r_dy;
          end else if (w_ny + BS >= VA) begin
            w_y  = Y_MAX;
            w_dy = ~r_dy;
          end else begin
            w_y = w_ny[11:0];
          end
          // dx already points at the conceding side on a miss, so re-serve keeps it.
          if (w_miss_l) begin
            w_score_l = 1'b1;
            w_state   = SCORE;
          end else if (w_miss_r) begin
            w_score_r = 1'b1;
            w_state   = SCORE;
          end else if (w_hit_r) begin
            w_x     = X_R_STOP;
            w_dx    = 1'b0;
            w_speed = w_speed_hit;
          end else if (w_hit_l) begin
            w_x     = X_L_STOP;
            w_dx    = 1'b1;
            w_speed = w_speed_hit;
          end else begin
            w_x = w_nx[11:0];
          end
        end
        SCORE: begin
          w_state = SERVE;
          w_x     = CX;
          w_y     = CY;
          w_speed = SPD0;
          w_cnt   = CNT_W'(1);
        end
        default: w_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_x       <= CX;
      r_y       <= CY;
      r_dx      <= 1'b1;
      r_dy      <= 1'b1;
      r_speed   <= SPD0;
      r_cnt     <= '0;
      r_vblnk_d <= 1'b0;
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_x       <= w_x;
      r_y       <= w_y;
      r_dx      <= w_dx;
      r_dy      <= w_dy;
      r_speed   <= w_speed;
      r_cnt     <= w_cnt;
      r_vblnk_d <= vga_in.vblnk;
      r_score_l <= w_score_l;
      r_score_r <= w_score_r;
    end
  end

  assign ball_x  = r_x;
  assign ball_y  = r_y;
  assign score_l = r_score_l;
  assign score_r = r_score_r;

  ball_draw #(
    .BALL_SIZE  (BALL_SIZE),
    .BALL_COLOR (BALL_COLOR)
  ) u_ball_draw (
    .pclk    (pclk),
    .rst     (rst),
    .vga_in  (vga_in),
    .vga_out (vga_out),
    .ball_x  (r_x),
    .ball_y  (r_y)
  );
endmodule

// File: tb/tb_draw_ball_ctl.sv
// tb/tb_draw_ball_ctl.sv - directed bench for draw_ball_ctl: reset, overlay, serve, bounces, paddle hit, misses
module tb_draw_ball_ctl;
  import pong_pkg::*;

  logic        pclk = 1'b0;
  logic        rst;
  logic [11:0] paddle_l_y, paddle_r_y;
  logic        game_en;
  logic [11:0] ball_x, ball_y;
  logic        score_l, score_r;

  int n_pass  = 0;
  int n_total = 0;
  int sl_cnt  = 0;
  int sr_cnt  = 0;

  draw_ball_ctl_if vin();
  draw_ball_ctl_if vout();

  draw_ball_ctl dut (
    .pclk       (pclk),
    .rst        (rst),
    .vga_in     (vin),
    .vga_out    (vout),
    .paddle_l_y (paddle_l_y),
    .paddle_r_y (paddle_r_y),
    .game_en    (game_en),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .score_l    (score_l),
    .score_r    (score_r)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic sample_scores();
    if (score_l === 1'b1) sl_cnt++;
    if (score_r === 1'b1) sr_cnt++;
  endtask

  // One short frame: vblank rises (one tick), stays up a cycle, then drops.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk); vin.vblnk = 1'b1;
      @(negedge pclk); sample_scores();
      @(negedge pclk); sample_scores(); vin.vblnk = 1'b0;
      @(negedge pclk); sample_scores();
    end
  endtask

  initial begin
    rst = 1'b1; game_en = 1'b0; paddle_l_y = 12'd500; paddle_r_y = 12'd506;
    vin.hcount = 11'd5; vin.vcount = 11'd7; vin.hsync = 1'b1; vin.vsync = 1'b1;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'hABC;
    @(negedge pclk); @(negedge pclk);
    check("rst_hcount_out", 32'(vout.hcount), 32'd0);
    check("rst_vsync_out", 32'(vout.vsync), 32'd0);
    check("rst_rgb_out", 32'(vout.rgb), 32'd0);
    check("rst_score_l", 32'(score_l), 32'd0);
    check("rst_score_r", 32'(score_r), 32'd0);
    check("rst_ball_x", 32'(ball_x), 32'd392);
    check("rst_ball_y", 32'(ball_y), 32'd292);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    rst = 1'b0;

    vin.hcount = 11'd392; vin.vcount = 11'd292; vin.rgb = 12'h123; vin.vsync = 1'b0;
    @(negedge pclk);
    check("ovl_corner_rgb", 32'(vout.rgb), 32'hFFF);
    check("pipe_hcount", 32'(vout.hcount), 32'd392);
    check("pipe_vcount", 32'(vout.vcount), 32'd292);
    check("pipe_hsync", 32'(vout.hsync), 32'd1);
    check("pipe_vsync", 32'(vout.vsync), 32'd0);
    vin.hcount = 11'd408;
    @(negedge pclk); check("ovl_right_edge_out", 32'(vout.rgb), 32'h123);
    vin.hcount = 11'd407; vin.vcount = 11'd307;
    @(negedge pclk); check("ovl_last_pixel", 32'(vout.rgb), 32'hFFF);
    vin.vcount = 11'd308;
    @(negedge pclk); check("ovl_bottom_edge_out", 32'(vout.rgb), 32'h123);
    vin.hcount = 11'd400; vin.vcount = 11'd300; vin.hblnk = 1'b1; vin.rgb = 12'h456;
    @(negedge pclk);
    check("ovl_hblank_rgb", 32'(vout.rgb), 32'h456);
    check("pipe_hblnk", 32'(vout.hblnk), 32'd1);
    vin.hblnk = 1'b0; vin.hcount = 11'd0; vin.vcount = 11'd0;

    game_en = 1'b1;
    tick_n(60);
    check("serve_held_x", 32'(ball_x), 32'd392);
    check("serve_state_move", 32'(dut.r_state), 32'(MOVE));
    tick_n(1);
    check("first_move_x", 32'(ball_x), 32'd394);
    check("first_move_y", 32'(ball_y), 32'd294);
    tick_n(145);
    check("bottom_wall_x", 32'(ball_x), 32'd684);
    check("bottom_wall_y", 32'(ball_y), 32'd584);
    tick_n(1);
    check("after_bottom_y", 32'(ball_y), 32'd582);
    tick_n(33);
    check("pre_hit_x", 32'(ball_x), 32'd752);
    check("pre_hit_y", 32'(ball_y), 32'd516);
    tick_n(1);
    check("paddle_r_hit_x", 32'(ball_x), 32'd754);
    check("paddle_r_hit_y", 32'(ball_y), 32'd514);
    tick_n(1);
    check("after_hit_x", 32'(ball_x), 32'd752);
    tick_n(255);
    check("top_pre_x", 32'(ball_x), 32'd242);
    check("top_pre_y", 32'(ball_y), 32'd2);
    tick_n(1);
    check("top_wall_y", 32'(ball_y), 32'd0);
    tick_n(1);
    check("after_top_y", 32'(ball_y), 32'd2);
    check("after_top_x", 32'(ball_x), 32'd238);
    tick_n(118);
    check("pre_miss_x", 32'(ball_x), 32'd2);
    check("pre_miss_y", 32'(ball_y), 32'd238);
    check("no_score_yet_l", 32'(sl_cnt), 32'd0);
    check("no_score_yet_r", 32'(sr_cnt), 32'd0);
    tick_n(1);
    check("miss_score_r_pulse", 32'(sr_cnt), 32'd1);
    check("miss_no_score_l", 32'(sl_cnt), 32'd0);
    check("miss_state_score", 32'(dut.r_state), 32'(SCORE));
    tick_n(1);
    check("reserve_state", 32'(dut.r_state), 32'(SERVE));
    check("reserve_x", 32'(ball_x), 32'd392);
    check("reserve_y", 32'(ball_y), 32'd292);
    tick_n(60);
    check("reserve_dx_left_x", 32'(ball_x), 32'd390);
    check("reserve_dy_kept_y", 32'(ball_y), 32'd294);

    @(negedge pclk); game_en = 1'b0;
    @(negedge pclk);
    check("disable_state", 32'(dut.r_state), 32'(IDLE));
    check("disable_x", 32'(ball_x), 32'd392);
    check("disable_y", 32'(ball_y), 32'd292);

    game_en = 1'b1;
    tick_n(61);
    check("reenable_move_y", 32'(ball_y), 32'd294);
    vin.hcount = 11'd77; rst = 1'b1;
    @(negedge pclk);
    check("midrst_x", 32'(ball_x), 32'd392);
    check("midrst_y", 32'(ball_y), 32'd292);
    check("midrst_hcount_out", 32'(vout.hcount), 32'd0);
    check("midrst_state", 32'(dut.r_state), 32'(IDLE));
    rst = 1'b0; vin.hcount = 11'd0;

    paddle_r_y = 12'd0; sl_cnt = 0; sr_cnt = 0;
    tick_n(240);
    check("run2_pre_x", 32'(ball_x), 32'd752);
    tick_n(15);
    check("run2_past_paddle_x", 32'(ball_x), 32'd782);
    check("run2_no_score", 32'(sl_cnt), 32'd0);
    tick_n(1);
    check("miss_score_l_pulse", 32'(sl_cnt), 32'd1);
    check("miss_l_no_score_r", 32'(sr_cnt), 32'd0);
    check("miss_l_state", 32'(dut.r_state), 32'(SCORE));
    tick_n(1);
    check("reserve2_state", 32'(dut.r_state), 32'(SERVE));
    check("reserve2_x", 32'(ball_x), 32'd392);
    check("reserve2_y", 32'(ball_y), 32'd292);
    check("reserve2_dx_right", 32'(dut.r_dx), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
